fetch_sequencer: RTL and testbench

Multi-cycle control FSM that sequences each instruction of the CPU through fetch, decode, execute and writeback. It drives the program counter's `latch`/`branch`/`immediate_address` controls and the instruction-memory request handshake, and strobes register-file writeback. It sits in `main_top` between the PC block, instruction memory and the execute unit.

---
 rtl/fetch_sequencer_if.sv | 54 +++++
 rtl/fetch_sequencer.sv | 117 +++++++++++
 tb/tb_fetch_sequencer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Handshake bundle between the fetch sequencer and its neighbours:
// instruction memory, execute unit, PC block and register file.
interface fetch_sequencer_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
);
  logic                   imem_req;
  logic                   imem_ack;
  logic [INSTR_WIDTH-1:0] instr_in;
  logic [INSTR_WIDTH-1:0] ir;

  logic                   ex_busy;
  logic                   ex_branch;
  logic [ADDR_WIDTH-1:0]  ex_target;
  logic                   ex_halt;
  logic                   ex_wb;

  logic                   pc_latch;
  logic                   pc_branch;
  logic [ADDR_WIDTH-1:0]  pc_target;
  logic                   rf_we;

  modport master (
    output imem_req,
    input  imem_ack,
    input  instr_in,
    output ir,
    input  ex_busy,
    input  ex_branch,
    input  ex_target,
    input  ex_halt,
    input  ex_wb,
    output pc_latch,
    output pc_branch,
    output pc_target,
    output rf_we
  );

  modport slave (
    input  imem_req,
    output imem_ack,
    output instr_in,
    input  ir,
    output ex_busy,
    output ex_branch,
    output ex_target,
    output ex_halt,
    output ex_wb,
    input  pc_latch,
    input  pc_branch,
    input  pc_target,
    input  rf_we
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, writeback.
//   state     | meaning
//   IDLE      | waiting for run
//   FETCH     | imem_req held until ack or fetch timeout
//   DECODE    | single cycle
//   EXECUTE   | waits while ex_busy, then captures branch/target/wb
//   WRITEBACK | pc_latch / rf_we strobes, retire
//   HALT      | absorbing until rst
module fetch_sequencer #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  fetch_sequencer_if.master  bus,
  output logic [2:0]         state,
  output logic [31:0]        retired,
  output logic               halted,
  output logic               timeout_err
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    WRITEBACK = 3'd4,
    HALT      = 3'd5
  } state_t;

  // Fetch wait timer counts down from MEM_TIMEOUT-1; terminal count at zero.
  localparam int              CNT_W     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(MEM_TIMEOUT - 1);

  state_t                 st;
  logic [CNT_W-1:0]       wait_cnt;
  logic [INSTR_WIDTH-1:0] ir_q;
  logic                   br_q;
  logic [ADDR_WIDTH-1:0]  tgt_q;
  logic                   wb_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= IDLE;
      wait_cnt    <= '0;
      ir_q        <= '0;
      br_q        <= 1'b0;
      tgt_q       <= '0;
      wb_q        <= 1'b0;
      retired     <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (run) begin
            st       <= FETCH;
            wait_cnt <= WAIT_LOAD;
          end
        end
        FETCH: begin
          if (bus.imem_ack) begin
            ir_q <= bus.instr_in;
            st   <= DECODE;
          end else if (wait_cnt == '0) begin
            st          <= HALT;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        DECODE: st <= EXECUTE;
        EXECUTE: begin
          if (!bus.ex_busy) begin
            // HALT retires but never reaches WRITEBACK, so no PC update.
            if (bus.ex_halt) begin
              st      <= HALT;
              retired <= sat_inc(retired);
            end else begin
              br_q  <= bus.ex_branch;
              tgt_q <= bus.ex_target;
              wb_q  <= bus.ex_wb;
              st    <= WRITEBACK;
            end
          end
        end
        WRITEBACK: begin
          retired <= sat_inc(retired);
          if (run) begin
            st       <= FETCH;
            wait_cnt <= WAIT_LOAD;
          end else begin
            st <= IDLE;
          end
        end
        HALT:    st <= HALT;
        default: st <= IDLE;
      endcase
    end
  end

  // Strobes come straight from registers so inputs never reach outputs combinationally.
  assign bus.imem_req  = (st == FETCH);
  assign bus.pc_latch  = (st == WRITEBACK);
  assign bus.pc_branch = (st == WRITEBACK) && br_q;
  assign bus.rf_we     = (st == WRITEBACK) && wb_q;
  assign bus.pc_target = tgt_q;
  assign bus.ir        = ir_q;
  assign halted        = (st == HALT);
  assign state         = st;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: outputs sampled on the falling edge,
// inputs changed right after sampling so the next rising edge sees them.
module tb_fetch_sequencer;
  localparam int AW = 32;
  localparam int IW = 32;
  localparam int MT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [2:0]  state;
  logic [31:0] retired;
  logic        halted;
  logic        timeout_err;

  int n_checks = 0;
  int n_errors = 0;
  int pulse_cnt;

  fetch_sequencer_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) bus();

  fetch_sequencer #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .MEM_TIMEOUT(MT)) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .bus         (bus.master),
    .state       (state),
    .retired     (retired),
    .halted      (halted),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1);
  end

  initial begin
    logic [2:0] stall_st [9];
    logic       stall_ack[9];
    logic       stall_bsy[9];
    logic [2:0] halt_st  [9];
    logic [2:0] to_st    [6];
    stall_st  = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4};
    stall_ack = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    stall_bsy = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    halt_st   = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5};
    to_st     = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd5, 3'd5};

    rst = 1'b1; run = 1'b0;
    bus.imem_ack = 1'b0; bus.instr_in = '0; bus.ex_busy = 1'b0;
    bus.ex_branch = 1'b0; bus.ex_target = '0; bus.ex_halt = 1'b0; bus.ex_wb = 1'b0;
    step(); step();
    check("rst_state",    64'(state), 64'd0);
    check("rst_retired",  64'(retired), 64'd0);
    check("rst_ir",       64'(bus.ir), 64'd0);
    check("rst_pc_latch", 64'(bus.pc_latch), 64'd0);
    check("rst_imem_req", 64'(bus.imem_req), 64'd0);
    check("rst_tmo",      64'(timeout_err), 64'd0);

    // straight-line: one instruction every 4 cycles
    rst = 1'b0; run = 1'b1; bus.imem_ack = 1'b1; bus.instr_in = 32'h1234_5678; bus.ex_wb = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      check($sformatf("sl_state_%0d", k), 64'(state), 64'(((k - 1) % 4) + 1));
      check($sformatf("sl_latch_%0d", k), 64'(bus.pc_latch), 64'((k % 4) == 0));
      check($sformatf("sl_rfwe_%0d", k),  64'(bus.rf_we), 64'((k % 4) == 0));
      check($sformatf("sl_br_%0d", k),    64'(bus.pc_branch), 64'd0);
    end
    step();
    check("sl_state13",  64'(state), 64'd1);
    check("sl_retired",  64'(retired), 64'd3);
    check("sl_ir",       64'(bus.ir), 64'h1234_5678);

    // branch then non-branch
    bus.ex_branch = 1'b1; bus.ex_target = 32'h17;
    step(); step(); step();
    check("br_state",   64'(state), 64'd4);
    check("br_branch",  64'(bus.pc_branch), 64'd1);
    check("br_target",  64'(bus.pc_target), 64'h17);
    check("br_latch",   64'(bus.pc_latch), 64'd1);
    bus.ex_branch = 1'b0; bus.ex_target = 32'h40;
    step();
    check("br_hold_branch", 64'(bus.pc_branch), 64'd0);
    check("br_hold_target", 64'(bus.pc_target), 64'h17);
    check("br_hold_latch",  64'(bus.pc_latch), 64'd0);
    step(); step(); step();
    check("nb_state",   64'(state), 64'd4);
    check("nb_branch",  64'(bus.pc_branch), 64'd0);
    check("nb_target",  64'(bus.pc_target), 64'h40);
    check("nb_retired", 64'(retired), 64'd4);

    // stalls: 3 fetch wait cycles, 2 busy execute cycles -> 9-cycle instruction
    bus.imem_ack = 1'b0; bus.ex_wb = 1'b0;
    pulse_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      check($sformatf("st_state_%0d", i), 64'(state), 64'(stall_st[i]));
      if (bus.pc_latch) pulse_cnt++;
      bus.imem_ack = stall_ack[i];
      bus.ex_busy  = stall_bsy[i];
    end
    check("st_pulses",  64'(pulse_cnt), 64'd1);
    check("st_rfwe",    64'(bus.rf_we), 64'd0);
    check("st_retired", 64'(retired), 64'd5);
    check("st_tmo",     64'(timeout_err), 64'd0);

    // drop run during DECODE: instruction completes, then IDLE
    bus.imem_ack = 1'b1;
    step();
    check("stop_fetch", 64'(state), 64'd1);
    step();
    check("stop_decode", 64'(state), 64'd2);
    run = 1'b0;
    step(); step();
    check("stop_wb",    64'(state), 64'd4);
    check("stop_latch", 64'(bus.pc_latch), 64'd1);
    step();
    check("stop_idle",    64'(state), 64'd0);
    check("stop_retired", 64'(retired), 64'd7);
    step();
    check("stop_idle2", 64'(state), 64'd0);
    check("stop_noreq", 64'(bus.imem_req), 64'd0);

    // restart with HALT instruction
    run = 1'b1; bus.ex_halt = 1'b1;
    pulse_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      check($sformatf("hl_state_%0d", i), 64'(state), 64'(halt_st[i]));
      if (bus.pc_latch) pulse_cnt++;
    end
    check("hl_halted",  64'(halted), 64'd1);
    check("hl_retired", 64'(retired), 64'd8);
    check("hl_pulses",  64'(pulse_cnt), 64'd0);

    // reset out of HALT
    rst = 1'b1; run = 1'b0; bus.ex_halt = 1'b0;
    step();
    check("rh_state",   64'(state), 64'd0);
    check("rh_halted",  64'(halted), 64'd0);
    check("rh_retired", 64'(retired), 64'd0);

    // fetch timeout with MEM_TIMEOUT=4
    rst = 1'b0; run = 1'b1; bus.imem_ack = 1'b0;
    pulse_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("to_state_%0d", i), 64'(state), 64'(to_st[i]));
      if (bus.imem_req) pulse_cnt++;
    end
    check("to_req_cycles", 64'(pulse_cnt), 64'd4);
    check("to_err",        64'(timeout_err), 64'd1);
    check("to_halted",     64'(halted), 64'd1);

    // reset held two cycles mid-EXECUTE after one retirement
    rst = 1'b1;
    step();
    rst = 1'b0; run = 1'b1; bus.imem_ack = 1'b1; bus.instr_in = 32'hCAFE_F00D;
    bus.ex_wb = 1'b1; bus.ex_busy = 1'b0;
    step(); step(); step(); step();
    check("rx_wb", 64'(state), 64'd4);
    bus.ex_busy = 1'b1;
    step(); step(); step();
    check("rx_exec",    64'(state), 64'd3);
    check("rx_retired", 64'(retired), 64'd1);
    check("rx_ir",      64'(bus.ir), 64'hCAFE_F00D);
    check("rx_target",  64'(bus.pc_target), 64'h40);
    rst = 1'b1;
    step(); step();
    check("rx_rst_state",   64'(state), 64'd0);
    check("rx_rst_retired", 64'(retired), 64'd0);
    check("rx_rst_latch",   64'(bus.pc_latch), 64'd0);
    check("rx_rst_ir",      64'(bus.ir), 64'd0);
    check("rx_rst_target",  64'(bus.pc_target), 64'd0);
    check("rx_rst_tmo",     64'(timeout_err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
